// File: rtl/es_pkg.sv
// es_pkg: shared types and helpers for the ES clock-division encoder.
package es_pkg;
   typedef enum logic [1:0] {IDLE, STREAM, DONE} es_enc_state_t;
   function automatic int es_frame_len(input int data_width, input int num_inputs);
      return 1 << (data_width * num_inputs);
   endfunction
endpackage

// File: rtl/es_clkdiv_encoder_if.sv
// es_clkdiv_encoder_if: operand/control inputs and stream outputs of the encoder.
interface es_clkdiv_encoder_if #(
   parameter int DATA_WIDTH = 5,
   parameter int NUM_INPUTS = 2
);
   typedef logic [DATA_WIDTH-1:0] op_arr_t [NUM_INPUTS];
   logic                  en;
   logic                  start;
   op_arr_t               bin_data_in;
   logic                  busy;
   logic [NUM_INPUTS-1:0] stream_out;
   logic                  stream_valid;
   logic                  stream_last;
   logic                  done;
   modport master (output en, start, bin_data_in, input busy, stream_out, stream_valid, stream_last, done);
   modport slave  (input en, start, bin_data_in, output busy, stream_out, stream_valid, stream_last, done);
endinterface

// File: rtl/es_digit_cmp.sv
// es_digit_cmp: unsigned digit-versus-operand less-than compare.
module es_digit_cmp #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] digit,
   input  logic [WIDTH-1:0] op,
   output logic             lt
);
   assign lt = digit < op;
endmodule

// File: rtl/es_clkdiv_encoder.sv
// es_clkdiv_encoder: clock-division binary-to-bitstream encoder; stream i compares digit i of a frame counter with operand i.
module es_clkdiv_encoder
   import es_pkg::*;
#(
   parameter int DATA_WIDTH = 5,
   parameter int NUM_INPUTS = 2
) (
   input logic               clk,
   input logic               rst,
   es_clkdiv_encoder_if.slave bus
);
   localparam int CNT_WIDTH = DATA_WIDTH * NUM_INPUTS;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(es_frame_len(DATA_WIDTH, NUM_INPUTS) - 1);
   es_enc_state_t         state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] op_q [NUM_INPUTS];
   logic [DATA_WIDTH-1:0] op_d [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] stream_q, stream_d, lt;
   logic                  valid_q, valid_d, last_q, last_d, done_q, done_d, busy_q, busy_d;
   logic                  accept, cnt_end;
   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cmp
      es_digit_cmp #(.WIDTH(DATA_WIDTH)) u_cmp (
         .digit(cnt_q[i*DATA_WIDTH +: DATA_WIDTH]),
         .op   (op_q[i]),
         .lt   (lt[i])
      );
   end
   // busy_q still high during the done cycle blocks an early restart
   assign accept  = (state_q == IDLE) && bus.en && bus.start && !busy_q;
   assign cnt_end = cnt_q == CNT_LAST;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      stream_d = stream_q;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      done_d   = 1'b0;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            busy_d = accept;
            if (accept) begin
               state_d = STREAM;
               cnt_d   = '0;
               op_d    = bus.bin_data_in;
            end
         end
         STREAM: if (bus.en) begin
            stream_d = lt;
            valid_d  = 1'b1;
            last_d   = cnt_end;
            cnt_d    = cnt_q + 1'b1;
            state_d  = cnt_end ? DONE : STREAM;
         end
         DONE: begin
            stream_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '{default: '0};
         stream_q <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         stream_q <= stream_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end
   assign bus.busy         = busy_q;
   assign bus.stream_out   = stream_q;
   assign bus.stream_valid = valid_q;
   assign bus.stream_last  = last_q;
   assign bus.done         = done_q;
endmodule

// File: tb/tb_es_clkdiv_encoder.sv
// tb_es_clkdiv_encoder: directed frame vectors for the 2x2-bit encoder (16-cycle frame).
module tb_es_clkdiv_encoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   es_clkdiv_encoder_if #(.DATA_WIDTH(2), .NUM_INPUTS(2)) b ();
   es_clkdiv_encoder #(.DATA_WIDTH(2), .NUM_INPUTS(2)) dut (.clk(clk), .rst(rst), .bus(b));
   typedef struct {
      int          op0;
      int          op1;
      logic [15:0] pat0;
      logic [15:0] pat1;
      int          and_ones;
      bit          stall;
      bit          spam;
   } vec_t;
   vec_t vecs [5];
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic run_frame(input int n);
      vec_t        v;
      int          idx, cyc, lasts, last_idx, and_ones;
      logic [15:0] p0, p1;
      logic        en_now;
      v = vecs[n];
      idx = 0; cyc = 0; lasts = 0; last_idx = -1; and_ones = 0; p0 = '0; p1 = '0;
      b.bin_data_in[0] = 2'(v.op0);
      b.bin_data_in[1] = 2'(v.op1);
      b.start = 1'b1;
      b.en    = 1'b1;
      step();
      chk($sformatf("v%0d busy_on_accept", n), b.busy, 1);
      chk($sformatf("v%0d no_valid_on_accept", n), b.stream_valid, 0);
      b.start = v.spam;
      while (idx < 16 && cyc < 100) begin
         en_now = v.stall ? (cyc % 2 == 0) : 1'b1;
         b.en = en_now;
         if (v.spam && idx == 5) begin
            b.bin_data_in[0] = 2'(v.op0) ^ 2'b11;
            b.bin_data_in[1] = 2'(v.op1) ^ 2'b11;
         end
         step();
         cyc++;
         if (!en_now) chk($sformatf("v%0d stall_valid c%0d", n, cyc), b.stream_valid, 0);
         if (b.stream_valid) begin
            p0[idx] = b.stream_out[0];
            p1[idx] = b.stream_out[1];
            if (&b.stream_out) and_ones++;
            if (b.stream_last) begin
               lasts++;
               last_idx = idx;
            end
            idx++;
         end
      end
      chk($sformatf("v%0d valid_count", n), idx, 16);
      chk($sformatf("v%0d pattern0", n), int'(p0), int'(v.pat0));
      chk($sformatf("v%0d pattern1", n), int'(p1), int'(v.pat1));
      chk($sformatf("v%0d and_ones", n), and_ones, v.and_ones);
      chk($sformatf("v%0d last_count", n), lasts, 1);
      chk($sformatf("v%0d last_index", n), last_idx, 15);
      b.en = !v.stall;
      step();
      chk($sformatf("v%0d done_pulse", n), b.done, 1);
      chk($sformatf("v%0d busy_in_done", n), b.busy, 1);
      chk($sformatf("v%0d valid_in_done", n), b.stream_valid, 0);
      chk($sformatf("v%0d stream_cleared", n), int'(b.stream_out), 0);
      step();
      chk($sformatf("v%0d done_cleared", n), b.done, 0);
      chk($sformatf("v%0d busy_fell", n), b.busy, 0);
      b.start = 1'b0;
      b.en    = 1'b1;
   endtask
   initial begin
      int cnt, cyc;
      vecs[0] = '{3, 2, 16'h7777, 16'h00FF, 6, 1'b0, 1'b0};
      vecs[1] = '{0, 3, 16'h0000, 16'h0FFF, 0, 1'b0, 1'b0};
      vecs[2] = '{3, 3, 16'h7777, 16'h0FFF, 9, 1'b0, 1'b0};
      vecs[3] = '{2, 1, 16'h3333, 16'h000F, 2, 1'b1, 1'b0};
      vecs[4] = '{3, 1, 16'h7777, 16'h000F, 3, 1'b0, 1'b1};
      b.en = 1'b0;
      b.start = 1'b0;
      b.bin_data_in[0] = '0;
      b.bin_data_in[1] = '0;
      step();
      step();
      chk("reset_busy", b.busy, 0);
      chk("reset_valid", b.stream_valid, 0);
      chk("reset_last", b.stream_last, 0);
      chk("reset_done", b.done, 0);
      chk("reset_stream", int'(b.stream_out), 0);
      rst = 1'b0;
      step();
      for (int i = 0; i < 5; i++) run_frame(i);
      b.start = 1'b1;
      b.en    = 1'b0;
      step();
      chk("idle_en0_no_accept", b.busy, 0);
      run_frame(0);
      b.bin_data_in[0] = 2'd3;
      b.bin_data_in[1] = 2'd2;
      b.start = 1'b1;
      b.en    = 1'b1;
      step();
      b.start = 1'b0;
      cnt = 0;
      cyc = 0;
      while (cnt < 7 && cyc < 50) begin
         step();
         cyc++;
         if (b.stream_valid) cnt++;
      end
      chk("reach_7th_bit", cnt, 7);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_busy", b.busy, 0);
      chk("rst_mid_valid", b.stream_valid, 0);
      chk("rst_mid_stream", int'(b.stream_out), 0);
      chk("rst_mid_last", b.stream_last, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("post_rst_done c%0d", i), b.done, 0);
         chk($sformatf("post_rst_busy c%0d", i), b.busy, 0);
      end
      run_frame(0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/es_clkdiv_encoder.md
Name: es_clkdiv_encoder

Overview:
Binary-to-bitstream transmitter for the deterministic stochastic (ES) datapath. It produces the NUM_INPUTS operand bitstreams consumed by the stream-side arithmetic and counter blocks.
Encoding is clock-division: input 0 is emitted as a unary stream. Input i repeats each bit for 2^(i*DATA_WIDTH) cycles. The bitwise AND of all streams therefore contains exactly the product of the operands, over one frame of 2^(NUM_INPUTS*DATA_WIDTH) cycles.
The block sits between the binary operand source and any stream consumer, and raises done once per frame.

Parameters:
DATA_WIDTH, 5, bits per binary operand; each operand ranges 0..2^DATA_WIDTH-1
NUM_INPUTS, 2, number of operands and output streams
CNT_WIDTH, DATA_WIDTH*NUM_INPUTS, frame counter width (derived; not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  global advance enable; low stalls the frame
start  in  1  request a frame; sampled only in IDLE with en=1
bin_data_in  in  [DATA_WIDTH-1:0] x [NUM_INPUTS-1:0]  unpacked operand array; captured on the accepting edge
busy  out  1  high from the accepting edge until done deasserts
stream_out  out  NUM_INPUTS  registered stream bits, one per operand
stream_valid  out  1  stream_out carries a new frame bit this cycle
stream_last  out  1  qualifies the final bit of the frame; only high with stream_valid
done  out  1  one-cycle pulse, the cycle after stream_last

Behaviour:
- Reset: while rst=1, all outputs are 0, the state is IDLE, the counter is 0 and the operand registers are 0. Reset takes effect immediately, including mid-frame; a partial frame is abandoned and no done is produced.
- States: IDLE, STREAM, DONE.
- IDLE -> STREAM on an edge with start=1 and en=1.
  - That edge captures the operands into op[i], clears cnt and sets busy=1.
  - start is ignored in STREAM and DONE; there is no queueing.
- STREAM, on each edge with en=1:
  - For each i, with digit_i = cnt[(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]: stream_out[i] <= (digit_i < op[i]), an unsigned compare.
  - stream_valid <= 1.
  - stream_last <= (cnt == all ones).
  - cnt <= cnt + 1.
  - If cnt was all ones, the next state is DONE.
- STREAM, on each edge with en=0:
  - stream_valid <= 0 and stream_last <= 0.
  - stream_out, cnt and the state hold.
  - Consumers must qualify on stream_valid.
- Latency: the first valid bit appears the cycle after the accepting edge. A frame with no stalls spans exactly 2^CNT_WIDTH valid cycles.
- DONE, on the next edge, regardless of en:
  - stream_valid <= 0, stream_last <= 0, stream_out <= 0.
  - done <= 1; the state becomes IDLE.
  - On the following edge, done <= 0 and busy <= 0.
  - done is high for exactly one cycle, and busy stays high during that cycle.
- Counts per frame:
  - ones in stream i = op[i] * 2^((NUM_INPUTS-1)*DATA_WIDTH).
  - ones in AND(stream_out) = product of op[i].
- Boundaries:
  - op = 0 gives an all-zero stream.
  - op = 2^DATA_WIDTH-1 gives a stream low only when digit_i is all ones.
  - cnt wraps to 0 after the last bit; the wrapped value is never emitted.
- The operand registers hold from capture until the next accepted start. Changes to bin_data_in mid-frame have no effect.
- start and rst together: rst wins.

Decomposition:
- Package es_pkg:
  - state enum es_enc_state_t {IDLE, STREAM, DONE};
  - localparam-style function es_frame_len(DATA_WIDTH, NUM_INPUTS) = 2^(DATA_WIDTH*NUM_INPUTS);
  - operand array typedef parameterised by DATA_WIDTH.
- Sub-module es_digit_cmp: a DATA_WIDTH-bit digit versus operand less-than compare, instantiated NUM_INPUTS times in a generate loop. The top level holds the FSM, the counter and the output registers.

Test Plan:
All cases use DATA_WIDTH=2, NUM_INPUTS=2, so the frame is 16 cycles.
1. op = {3,2}, en=1 -> 16 valid cycles; stream0 ones = 12, stream1 ones = 8, AND ones = 6; stream_last on the 16th valid bit; done pulses 1 cycle later; busy falls the cycle after done.
2. op = {0,3} and op = {3,3} -> first: stream0 all 0, AND = 0. Second: each stream has 12 ones, AND = 9; stream1 pattern is 1111 1111 1111 0000, and stream0 repeats 1110.
3. op = {2,1} with en toggling 1,0,1,0 during STREAM -> exactly 16 valid bits, identical to the unstalled sequence; stream_valid is 0 on stalled cycles; AND ones = 2.
4. start pulsed every cycle during a frame, plus bin_data_in changed mid-frame -> no restart; counts match the captured operands; a new frame is accepted only after busy falls.
5. rst asserted at the 7th valid bit -> all outputs are 0 immediately, no done; a subsequent start runs a complete correct 16-cycle frame.
6. start with en=0 in IDLE -> not accepted and busy stays 0; en=1 on the next cycle with start=1 -> accepted.
